// File: rtl/analyzer_pkg.sv
// Shared definitions for the analyzer capture and readback controllers:
// trace depth derivation, state encodings and packet field layout.
package analyzer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_FLUSH = 3'd4
  } capture_state_t;

  localparam int unsigned PKT_SAMPLE_LSB = 0;

  // The delta field sits directly above the raw sample in each packet.
  function automatic int unsigned pkt_delta_lsb(input int unsigned sample_width);
    return sample_width;
  endfunction

  function automatic int unsigned packet_depth(input int unsigned capacity,
                                               input int unsigned packet_width,
                                               input int unsigned word_width);
    int unsigned words_per_packet;
    words_per_packet = packet_width / 8 / word_width;
    return capacity / word_width / words_per_packet;
  endfunction

  function automatic int unsigned max_sample_number(input int unsigned capacity,
                                                    input int unsigned packet_width,
                                                    input int unsigned word_width);
    return packet_depth(capacity, packet_width, word_width) - 1;
  endfunction

endpackage

// File: rtl/analyzer_delta_timer.sv
// Saturating cycle counter giving the gap between consecutive captured samples.
// start parks it at 0 so the first sample of a run carries delta 0.
module analyzer_delta_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             capture,
  output logic [WIDTH-1:0] delta
);

  logic running;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      delta   <= '0;
      running <= 1'b0;
    end else if (start) begin
      delta   <= '0;
      running <= 1'b0;
    end else if (capture) begin
      delta   <= WIDTH'(1);
      running <= 1'b1;
    end else if (running && (delta != '1)) begin
      delta <= delta + 1'b1;
    end
  end

endmodule

// File: rtl/analyzer_capture_fsm.sv
// Capture stage: packs qualified samples with a cycle delta, writes them into the
// circular trace memory and sequences pre-fill, trigger and post-trigger capture.
//
// state    | meaning
// IDLE     | waiting for arm; results of the last run are valid
// FILL     | capturing the pre-trigger history, trigger ignored
// ARMED    | capturing with wrap, looking for a trigger
// POST     | capturing the post-trigger samples
// FLUSH    | no new captures, draining the holding entry
module analyzer_capture_fsm
  import analyzer_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH        = 16,
  parameter int unsigned SAMPLE_PACKET_WIDTH = 32,
  parameter int unsigned MEMORY_CAPACITY     = 2**27,
  parameter int unsigned MEMORY_WORD_WIDTH   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           arm,
  input  logic                           abort,
  input  logic [31:0]                    pre_trigger_samples,
  input  logic [31:0]                    post_trigger_samples,
  input  logic                           sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]        sample,
  input  logic                           trigger,
  output logic                           write_req,
  input  logic                           write_allowed,
  output logic [31:0]                    writeSampleNumber,
  output logic [SAMPLE_PACKET_WIDTH-1:0] write_packet,
  output logic                           idle,
  output logic                           triggered,
  output logic                           capture_done,
  output logic                           overrun,
  output logic [31:0]                    sampleNumber_Begin,
  output logic [31:0]                    sampleNumber_End,
  output logic [31:0]                    trigger_sample_number
);

  localparam int unsigned DELTA_WIDTH = SAMPLE_PACKET_WIDTH - pkt_delta_lsb(SAMPLE_WIDTH);
  localparam logic [31:0] DEPTH =
    32'(packet_depth(MEMORY_CAPACITY, SAMPLE_PACKET_WIDTH, MEMORY_WORD_WIDTH));
  localparam logic [31:0] MAX_SAMPLE_NUMBER =
    32'(max_sample_number(MEMORY_CAPACITY, SAMPLE_PACKET_WIDTH, MEMORY_WORD_WIDTH));

  capture_state_t state;
  logic [31:0] wr_slot, captured_count, pre_count, post_count, pre_target, post_target;
  logic        aborted;
  logic [DELTA_WIDTH-1:0] delta;

  logic        capturing, drain, take, drop, timer_start;
  logic [31:0] wr_slot_next, pre_next, post_next;

  assign capturing    = (state == ST_FILL) || (state == ST_ARMED) || (state == ST_POST);
  assign drain        = write_req & write_allowed;
  // An abort cycle neither captures nor drops: the run is already stopping.
  assign take         = sample_valid & capturing & ~abort & (~write_req | drain);
  assign drop         = sample_valid & capturing & ~abort & write_req & ~drain;
  assign wr_slot_next = (wr_slot == MAX_SAMPLE_NUMBER) ? 32'd0 : wr_slot + 32'd1;
  assign pre_next     = pre_count + 32'd1;
  assign post_next    = post_count + 32'd1;
  assign timer_start  = (state == ST_IDLE) & arm;

  analyzer_delta_timer #(
    .WIDTH(DELTA_WIDTH)
  ) u_delta_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (timer_start),
    .capture(take),
    .delta  (delta)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= ST_IDLE;
      wr_slot               <= '0;
      captured_count        <= '0;
      pre_count             <= '0;
      post_count            <= '0;
      pre_target            <= '0;
      post_target           <= '0;
      aborted               <= 1'b0;
      write_req             <= 1'b0;
      writeSampleNumber     <= '0;
      write_packet          <= '0;
      idle                  <= 1'b1;
      triggered             <= 1'b0;
      capture_done          <= 1'b0;
      overrun               <= 1'b0;
      sampleNumber_Begin    <= '0;
      sampleNumber_End      <= '0;
      trigger_sample_number <= '0;
    end else begin
      capture_done <= 1'b0;
      if (drain) write_req <= 1'b0;
      if (take) begin
        write_req         <= 1'b1;
        writeSampleNumber <= wr_slot;
        write_packet      <= {delta, sample};
        wr_slot           <= wr_slot_next;
        if (captured_count != DEPTH) captured_count <= captured_count + 32'd1;
      end
      if (drop) overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (arm) begin
            state          <= (pre_trigger_samples == 32'd0) ? ST_ARMED : ST_FILL;
            idle           <= 1'b0;
            wr_slot        <= '0;
            captured_count <= '0;
            pre_count      <= '0;
            post_count     <= '0;
            triggered      <= 1'b0;
            overrun        <= 1'b0;
            aborted        <= 1'b0;
            pre_target     <= pre_trigger_samples;
            post_target    <= (post_trigger_samples == 32'd0) ? 32'd1 : post_trigger_samples;
          end
        end
        ST_FILL: begin
          if (abort) begin
            state   <= ST_FLUSH;
            aborted <= 1'b1;
          end else if (take) begin
            pre_count <= pre_next;
            if (pre_next >= pre_target) state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (abort) begin
            state   <= ST_FLUSH;
            aborted <= 1'b1;
          end else if (take && trigger) begin
            triggered             <= 1'b1;
            trigger_sample_number <= wr_slot;
            post_count            <= 32'd1;
            state                 <= (post_target == 32'd1) ? ST_FLUSH : ST_POST;
          end
        end
        ST_POST: begin
          if (abort) begin
            state   <= ST_FLUSH;
            aborted <= 1'b1;
          end else if (take) begin
            post_count <= post_next;
            if (post_next >= post_target) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (!write_req || drain) begin
            state              <= ST_IDLE;
            idle               <= 1'b1;
            sampleNumber_End   <= wr_slot;
            sampleNumber_Begin <= (captured_count < DEPTH) ? 32'd0 : wr_slot;
            capture_done       <= ~aborted;
          end
        end
        default: begin
          state <= ST_IDLE;
          idle  <= 1'b1;
        end
      endcase
    end
  end

endmodule
